// File: rtl/stream_pkg.sv
// Shared types and default widths for the dual-lane ready/valid traffic source.
package stream_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_GAP_W = 4;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} lane_state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic                 valid;
  } lane_out_t;

endpackage

// File: rtl/stream_source_lane.sv
// One transmit lane: emits a burst of incrementing words with optional idle gaps,
// honouring backpressure. Valid comes straight from the state register.
module stream_source_lane
  import stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [WIDTH-1:0] seed,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] sent,
  output lane_state_t      state
);

  lane_state_t      state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [GAP_W-1:0] gap_ld_reg, gap_ld_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [CNT_W-1:0] sent_reg, sent_next;
  logic             handshake;

  assign valid     = (state_reg == SEND);
  assign handshake = valid && ready;

  always_comb begin
    state_next     = state_reg;
    data_next      = data_reg;
    remaining_next = remaining_reg;
    gap_ld_next    = gap_ld_reg;
    gap_cnt_next   = gap_cnt_reg;
    sent_next      = sent_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          data_next      = seed;
          remaining_next = burst_len;
          gap_ld_next    = gap_len;
          sent_next      = '0;
          state_next     = (burst_len != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        // start is deliberately not looked at here: a running burst keeps its length
        if (handshake) begin
          data_next      = data_reg + WIDTH'(1);
          remaining_next = remaining_reg - CNT_W'(1);
          if (sent_reg != '1) sent_next = sent_reg + CNT_W'(1);
          if (remaining_reg == CNT_W'(1)) begin
            state_next = DONE;
          end else if (gap_ld_reg != '0) begin
            state_next   = GAP;
            gap_cnt_next = gap_ld_reg;
          end
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        if (gap_cnt_reg == GAP_W'(1)) state_next = SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      remaining_reg <= '0;
      gap_ld_reg    <= '0;
      gap_cnt_reg   <= '0;
      sent_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      data_reg      <= data_next;
      remaining_reg <= remaining_next;
      gap_ld_reg    <= gap_ld_next;
      gap_cnt_reg   <= gap_cnt_next;
      sent_reg      <= sent_next;
    end
  end

  assign data  = data_reg;
  assign sent  = sent_reg;
  assign state = state_reg;

endmodule

// File: rtl/dual_stream_source.sv
// Two independent burst-generating lanes sharing start/length controls;
// busy/done summarise both lane states.
module dual_stream_source
  import stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [WIDTH-1:0] seed_0,
  input  logic [WIDTH-1:0] seed_1,
  output logic [WIDTH-1:0] O_0_data,
  output logic [WIDTH-1:0] O_1_data,
  output logic             O_0_valid,
  output logic             O_1_valid,
  input  logic             O_0_ready,
  input  logic             O_1_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_0,
  output logic [CNT_W-1:0] sent_1
);

  logic [WIDTH-1:0] seed_arr  [2];
  logic             ready_arr [2];
  logic [WIDTH-1:0] data_arr  [2];
  logic             valid_arr [2];
  logic [CNT_W-1:0] sent_arr  [2];
  lane_state_t      state_arr [2];

  assign seed_arr[0]  = seed_0;
  assign seed_arr[1]  = seed_1;
  assign ready_arr[0] = O_0_ready;
  assign ready_arr[1] = O_1_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      stream_source_lane #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
      ) u_lane (
        .clk      (CLK),
        .srst     (RESET),
        .start    (start),
        .burst_len(burst_len),
        .gap_len  (gap_len),
        .seed     (seed_arr[gi]),
        .ready    (ready_arr[gi]),
        .data     (data_arr[gi]),
        .valid    (valid_arr[gi]),
        .sent     (sent_arr[gi]),
        .state    (state_arr[gi])
      );
    end
  endgenerate

  assign O_0_data  = data_arr[0];
  assign O_1_data  = data_arr[1];
  assign O_0_valid = valid_arr[0];
  assign O_1_valid = valid_arr[1];
  assign sent_0    = sent_arr[0];
  assign sent_1    = sent_arr[1];

  always_comb begin
    busy = (state_arr[0] == SEND) || (state_arr[0] == GAP) ||
           (state_arr[1] == SEND) || (state_arr[1] == GAP);
    done = (state_arr[0] == DONE) && (state_arr[1] == DONE);
  end

endmodule

// File: tb/tb_dual_stream_source.sv
// Bench for dual_stream_source: cycle tables, hand-written corner sequences and
// randomized bursts checked against a protocol-level scoreboard.
module tb_dual_stream_source;

  localparam int WIDTH = 5;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [GAP_W-1:0] gap_len;
  logic [WIDTH-1:0] seed_0, seed_1;
  logic [WIDTH-1:0] O_0_data, O_1_data;
  logic             O_0_valid, O_1_valid;
  logic             O_0_ready, O_1_ready;
  logic             busy, done;
  logic [CNT_W-1:0] sent_0, sent_1;

  dual_stream_source #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .burst_len(burst_len), .gap_len(gap_len),
    .seed_0(seed_0), .seed_1(seed_1), .O_0_data(O_0_data), .O_1_data(O_1_data),
    .O_0_valid(O_0_valid), .O_1_valid(O_1_valid), .O_0_ready(O_0_ready), .O_1_ready(O_1_ready),
    .busy(busy), .done(done), .sent_0(sent_0), .sent_1(sent_1)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int st, bl, gl, s0, s1, r0, r1, v0, d0, v1, d1, bz, dn, n0, n1;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic row(input int st, bl, gl, s0, s1, r0, r1, v0, d0, v1, d1, bz, dn, n0, n1);
    vecs.push_back('{st, bl, gl, s0, s1, r0, r1, v0, d0, v1, d1, bz, dn, n0, n1});
  endtask

  task automatic launch(input int bl, gl, s0, s1);
    start = 1'b1; burst_len = CNT_W'(bl); gap_len = GAP_W'(gl);
    seed_0 = WIDTH'(s0); seed_1 = WIDTH'(s1);
    tick();
    start = 1'b0;
  endtask

  initial begin
    int acc[2], gap_left[2], nxt[2], rdy[2];
    int bl, gl, cyc;
    bit fin[2], exp_v, ok_end;
    logic v;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] n;

    RESET = 1'b1; start = 1'b0; burst_len = '0; gap_len = '0;
    seed_0 = '0; seed_1 = '0; O_0_ready = 1'b1; O_1_ready = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    chk("rst_v0", O_0_valid, 0); chk("rst_v1", O_1_valid, 0);
    chk("rst_d0", O_0_data, 0);  chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);    chk("rst_sent0", sent_0, 0);
    $display("reset released");

    // burst 4, no gap, lane1 wraps 31->0
    row(1,4,0,3,30, 1,1, 0,0,0,0, 0,0, 0,0);
    row(0,0,0,0,0,  1,1, 1,3,1,30, 1,0, 0,0);
    row(0,0,0,0,0,  1,1, 1,4,1,31, 1,0, 1,1);
    row(0,0,0,0,0,  1,1, 1,5,1,0,  1,0, 2,2);
    row(0,0,0,0,0,  1,1, 1,6,1,1,  1,0, 3,3);
    row(0,0,0,0,0,  1,1, 0,0,0,0,  0,1, 4,4);
    // burst 3, gap 2
    row(1,3,2,0,8,  1,1, 0,0,0,0,  0,1, 4,4);
    row(0,0,0,0,0,  1,1, 1,0,1,8,  1,0, 0,0);
    row(0,0,0,0,0,  1,1, 0,0,0,0,  1,0, 1,1);
    row(0,0,0,0,0,  1,1, 0,0,0,0,  1,0, 1,1);
    row(0,0,0,0,0,  1,1, 1,1,1,9,  1,0, 1,1);
    row(0,0,0,0,0,  1,1, 0,0,0,0,  1,0, 2,2);
    row(0,0,0,0,0,  1,1, 0,0,0,0,  1,0, 2,2);
    row(0,0,0,0,0,  1,1, 1,2,1,10, 1,0, 2,2);
    row(0,0,0,0,0,  1,1, 0,0,0,0,  0,1, 3,3);
    // burst 5, lane0 stalled on cycles 2..5
    row(1,5,0,10,20, 1,1, 0,0,0,0,  0,1, 3,3);
    row(0,0,0,0,0,  1,1, 1,10,1,20, 1,0, 0,0);
    row(0,0,0,0,0,  0,1, 1,11,1,21, 1,0, 1,1);
    row(0,0,0,0,0,  0,1, 1,11,1,22, 1,0, 1,2);
    row(0,0,0,0,0,  0,1, 1,11,1,23, 1,0, 1,3);
    row(0,0,0,0,0,  0,1, 1,11,1,24, 1,0, 1,4);
    row(0,0,0,0,0,  1,1, 1,11,0,0,  1,0, 1,5);
    row(0,0,0,0,0,  1,1, 1,12,0,0,  1,0, 2,5);
    row(0,0,0,0,0,  1,1, 1,13,0,0,  1,0, 3,5);
    row(0,0,0,0,0,  1,1, 1,14,0,0,  1,0, 4,5);
    row(0,0,0,0,0,  1,1, 0,0,0,0,   0,1, 5,5);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st[0]; burst_len = CNT_W'(vecs[i].bl); gap_len = GAP_W'(vecs[i].gl);
      seed_0 = WIDTH'(vecs[i].s0); seed_1 = WIDTH'(vecs[i].s1);
      O_0_ready = vecs[i].r0[0]; O_1_ready = vecs[i].r1[0];
      chk($sformatf("row%0d_v0", i), O_0_valid, vecs[i].v0);
      chk($sformatf("row%0d_v1", i), O_1_valid, vecs[i].v1);
      if (vecs[i].v0 != 0) chk($sformatf("row%0d_d0", i), O_0_data, vecs[i].d0);
      if (vecs[i].v1 != 0) chk($sformatf("row%0d_d1", i), O_1_data, vecs[i].d1);
      chk($sformatf("row%0d_busy", i), busy, vecs[i].bz);
      chk($sformatf("row%0d_done", i), done, vecs[i].dn);
      chk($sformatf("row%0d_sent0", i), sent_0, vecs[i].n0);
      chk($sformatf("row%0d_sent1", i), sent_1, vecs[i].n1);
      $display("row %0d v0=%0d d0=%0d v1=%0d d1=%0d busy=%0d done=%0d",
               i, O_0_valid, O_0_data, O_1_valid, O_1_data, busy, done);
      tick();
    end
    start = 1'b0; O_0_ready = 1'b1; O_1_ready = 1'b1;

    // re-start mid-burst must be ignored
    launch(4, 0, 5, 5);
    for (int k = 1; k <= 4; k++) begin
      start = (k == 2); burst_len = 9; seed_0 = 0;
      chk("restart_v0", O_0_valid, 1);
      chk("restart_d0", O_0_data, 5 + k - 1);
      tick();
    end
    start = 1'b0;
    chk("restart_done", done, 1); chk("restart_sent0", sent_0, 4);
    tick();
    chk("restart_idle_v0", O_0_valid, 0);
    $display("restart-ignored sequence sent0=%0d", sent_0);

    // start coinciding with the final handshake is ignored
    launch(2, 0, 1, 1);
    tick();
    start = 1'b1; burst_len = 5;
    tick();
    start = 1'b0;
    chk("lastst_done", done, 1); chk("lastst_v0", O_0_valid, 0); chk("lastst_sent0", sent_0, 2);
    tick();
    chk("lastst_v0_after", O_0_valid, 0); chk("lastst_done_after", done, 1);
    $display("start-on-final-handshake sequence done=%0d", done);

    // zero-length burst
    launch(0, 0, 4, 4);
    for (int k = 0; k < 3; k++) begin
      chk("zero_done", done, 1); chk("zero_busy", busy, 0);
      chk("zero_v0", O_0_valid, 0); chk("zero_v1", O_1_valid, 0);
      chk("zero_sent0", sent_0, 0);
      tick();
    end
    $display("zero-length burst done=%0d", done);

    // maximum burst length drives sent to its ceiling
    launch(255, 0, 0, 0);
    for (int k = 0; k < 255; k++) tick();
    chk("max_sent0", sent_0, 255); chk("max_sent1", sent_1, 255); chk("max_done", done, 1);
    $display("max burst sent0=%0d sent1=%0d", sent_0, sent_1);

    // reset mid-burst, with a start in the same cycle
    launch(10, 1, 7, 7);
    tick(); tick();
    RESET = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    RESET = 1'b0;
    chk("mrst_v0", O_0_valid, 0); chk("mrst_v1", O_1_valid, 0);
    chk("mrst_sent0", sent_0, 0); chk("mrst_done", done, 0);
    chk("mrst_busy", busy, 0);    chk("mrst_d0", O_0_data, 0);
    launch(2, 0, 9, 17);
    chk("mrst_relaunch_d0", O_0_data, 9); chk("mrst_relaunch_d1", O_1_data, 17);
    chk("mrst_relaunch_v0", O_0_valid, 1);
    tick();
    chk("mrst_relaunch_d0b", O_0_data, 10);
    tick();
    chk("mrst_relaunch_done", done, 1);
    $display("mid-burst reset sequence done=%0d", done);

    // randomized bursts against a protocol-level scoreboard
    for (int run = 0; run < 10; run++) begin
      bl = $urandom_range(10, 30);
      gl = $urandom_range(0, 3);
      nxt[0] = $urandom_range(0, 31);
      nxt[1] = $urandom_range(0, 31);
      launch(bl, gl, nxt[0], nxt[1]);
      acc = '{0, 0}; gap_left = '{0, 0};
      ok_end = 1'b0;
      for (cyc = 0; cyc < 2000; cyc++) begin
        rdy[0] = ($urandom_range(0, 3) != 0);
        rdy[1] = ($urandom_range(0, 3) != 0);
        O_0_ready = rdy[0][0]; O_1_ready = rdy[1][0];
        for (int l = 0; l < 2; l++) begin
          v = (l == 0) ? O_0_valid : O_1_valid;
          d = (l == 0) ? O_0_data : O_1_data;
          n = (l == 0) ? sent_0 : sent_1;
          fin[l] = (acc[l] == bl);
          exp_v = !fin[l] && (gap_left[l] == 0);
          chk($sformatf("rnd_v%0d", l), v, exp_v);
          if (exp_v && v) chk($sformatf("rnd_d%0d", l), d, nxt[l]);
          chk($sformatf("rnd_sent%0d", l), n, acc[l]);
        end
        chk("rnd_done", done, fin[0] && fin[1]);
        chk("rnd_busy", busy, !(fin[0] && fin[1]));
        if (fin[0] && fin[1]) begin
          ok_end = 1'b1;
          break;
        end
        for (int l = 0; l < 2; l++) begin
          if (!fin[l]) begin
            if (gap_left[l] == 0) begin
              if (rdy[l] != 0) begin
                acc[l]++;
                nxt[l] = (nxt[l] + 1) % (1 << WIDTH);
                gap_left[l] = (acc[l] < bl) ? gl : 0;
              end
            end else begin
              gap_left[l]--;
            end
          end
        end
        tick();
      end
      if (!ok_end) chk("rnd_timeout", 0, 1);
      $display("random burst %0d len=%0d gap=%0d cycles=%0d sent0=%0d sent1=%0d",
               run, bl, gl, cyc, sent_0, sent_1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
